// File: rtl/rst_seq_pkg.sv
// Shared encodings for the staged reset-release sequencer: FSM states and
// last-reset cause codes.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    REL_IO   = 3'd1,
    REL_UART = 3'd2,
    REL_CPU  = 3'd3,
    RUN      = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

endpackage

// File: rtl/rst_seq_ctrl_seq_timer.sv
// Free-running terminal-count timer shared by the release stages and the
// watchdog; wraps to zero after TERM and holds zero while clr is high.
module seq_timer #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc = (count_q == TERM);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset release: I/O first, then UART, then CPU. Defining
// RST_SEQ_WDT_EN adds a watchdog that re-enters the sequence on a missed kick.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGE_DLY  = 16,
  parameter int unsigned WDT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       rst_io_out,
  output logic       rst_uart_out,
  output logic       rst_cpu_out,
  output logic       ready,
  output logic [1:0] cause
);

  localparam int unsigned STG_W = $clog2(STAGE_DLY);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       rst_io_q, rst_io_d;
  logic       rst_uart_q, rst_uart_d;
  logic       rst_cpu_q, rst_cpu_d;
  logic       ready_q, ready_d;
  logic       stg_clr, stg_tc;
  logic       wdt_expire;

  // Only the two timed stages count; everywhere else the counter sits at zero.
  assign stg_clr = (state_q != HOLD) && (state_q != REL_IO);

  seq_timer #(
    .WIDTH (STG_W),
    .TERM  (STG_W'(STAGE_DLY - 1))
  ) u_stage_timer (
    .clk (clk),
    .rst (rst),
    .clr (stg_clr),
    .en  (1'b1),
    .tc  (stg_tc)
  );

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES);

  logic wdt_clr, wdt_tc;

  assign wdt_clr    = (state_q != RUN) || wdt_kick;
  assign wdt_expire = wdt_tc && (state_q == RUN) && !wdt_kick;

  seq_timer #(
    .WIDTH (WDT_W),
    .TERM  (WDT_W'(WDT_CYCLES - 1))
  ) u_wdt_timer (
    .clk (clk),
    .rst (rst),
    .clr (wdt_clr),
    .en  (1'b1),
    .tc  (wdt_tc)
  );
`else
  logic unused_wdt;

  assign unused_wdt = wdt_kick & (WDT_CYCLES != 0);
  assign wdt_expire = 1'b0;
`endif

  // Outputs decode the next state so every pin comes straight from a flop.
  // Ready is raised on the same edge that frees the CPU.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      HOLD:     if (stg_tc) state_d = REL_IO;
      REL_IO:   if (stg_tc) state_d = REL_UART;
      REL_UART: state_d = REL_CPU;
      REL_CPU:  state_d = RUN;
      RUN: begin
        if (sw_rst_req) begin
          state_d = HOLD;
          cause_d = CAUSE_SW;
        end else if (wdt_expire) begin
          state_d = HOLD;
          cause_d = CAUSE_WDT;
        end
      end
      default:  state_d = HOLD;
    endcase
    rst_io_d   = (state_d == HOLD);
    rst_uart_d = (state_d == HOLD) || (state_d == REL_IO);
    rst_cpu_d  = rst_uart_d || (state_d == REL_UART);
    ready_d    = (state_d == REL_CPU) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HOLD;
      cause_q    <= CAUSE_POR;
      rst_io_q   <= 1'b1;
      rst_uart_q <= 1'b1;
      rst_cpu_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rst_io_q   <= rst_io_d;
      rst_uart_q <= rst_uart_d;
      rst_cpu_q  <= rst_cpu_d;
      ready_q    <= ready_d;
    end
  end

  assign rst_io_out   = rst_io_q;
  assign rst_uart_out = rst_uart_q;
  assign rst_cpu_out  = rst_cpu_q;
  assign ready        = ready_q;
  assign cause        = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with STAGE_DLY=4; the watchdog scenarios
// are compiled only when RST_SEQ_WDT_EN is defined.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int SD  = 4;
  localparam int WDT = 8;

  typedef struct {
    logic       sw;
    logic       kick;
    logic [5:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_io_out, rst_uart_out, rst_cpu_out, ready;
  logic [1:0] cause;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[$];

  rst_seq_ctrl #(
    .STAGE_DLY  (SD),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst_req   (sw_rst_req),
    .wdt_kick     (wdt_kick),
    .rst_io_out   (rst_io_out),
    .rst_uart_out (rst_uart_out),
    .rst_cpu_out  (rst_cpu_out),
    .ready        (ready),
    .cause        (cause)
  );

  always #5 clk = ~clk;

  // Expected {io, uart, cpu, ready, cause} k edges after a release starts.
  function automatic logic [5:0] seq_exp(int k, logic [1:0] c);
    return {k < SD, k < 2 * SD, k < 2 * SD + 1, k >= 2 * SD + 1, c};
  endfunction

  task automatic apply_stimulus(input logic sw, input logic kick);
    sw_rst_req = sw;
    wdt_kick   = kick;
    @(posedge clk);
    #1;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {rst_io_out, rst_uart_out, rst_cpu_out, ready, cause};
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial begin
    int drops;
    int t;

    for (int k = 1; k <= 11; k++)
      vecs.push_back('{sw: 1'b0, kick: logic'(k % 3 == 0), exp: seq_exp(k, CAUSE_POR)});
    vecs.push_back('{sw: 1'b1, kick: 1'b0, exp: {3'b111, 1'b0, CAUSE_SW}});
    for (int k = 1; k <= 11; k++)
      vecs.push_back('{sw: logic'(k == 2 || k == 2 * SD + 1), kick: 1'b0,
                       exp: seq_exp(k, CAUSE_SW)});

    #12;
    check_output("por_hold", {3'b111, 1'b0, CAUSE_POR});
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].sw, vecs[i].kick);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Abort a software-triggered sequence with rst while in REL_IO.
    apply_stimulus(1'b1, 1'b0);
    check_output("sw_from_run", {3'b111, 1'b0, CAUSE_SW});
    repeat (SD + 1) apply_stimulus(1'b0, 1'b0);
    check_output("rel_io_before_abort", seq_exp(SD + 1, CAUSE_SW));
    #2;
    rst = 1'b0;
    #1;
    check_output("async_abort", {3'b111, 1'b0, CAUSE_POR});
    @(posedge clk);
    #1;
    check_output("abort_held", {3'b111, 1'b0, CAUSE_POR});
    rst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output($sformatf("restart_k%0d", k), seq_exp(k, CAUSE_POR));
    end

`ifndef RST_SEQ_WDT_EN
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, logic'(i % 4 == 0));
      if (ready !== 1'b1) drops++;
    end
    check_int("no_wdt_reassert", drops, 0);
    check_output("run_after_idle", seq_exp(11, CAUSE_POR));
`else
    t = 0;
    while (ready === 1'b1 && t < 30) begin
      apply_stimulus(1'b0, 1'b0);
      t++;
    end
    check_int("wdt_fall_edge", 11 + t, 2 * SD + 2 + WDT);
    check_output("wdt_reassert", {3'b111, 1'b0, CAUSE_WDT});
    t = 0;
    while (ready !== 1'b1 && t < 30) begin
      apply_stimulus(1'b0, 1'b0);
      t++;
    end
    check_int("wdt_rerelease", t, 2 * SD + 1);
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, logic'(i % 5 == 0));
      if (ready !== 1'b1) drops++;
    end
    check_int("kicked_no_reassert", drops, 0);
    apply_stimulus(1'b0, 1'b1);
    repeat (WDT - 1) apply_stimulus(1'b0, 1'b0);
    check_output("pre_expiry", seq_exp(11, CAUSE_WDT));
    apply_stimulus(1'b1, 1'b0);
    check_output("sw_wdt_coincident", {3'b111, 1'b0, CAUSE_SW});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
